// File: rtl/systolic_mma_engine_if.sv
// Operand/result handshake bundle for the systolic MMA engine.
// Both streams use valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface systolic_mma_engine_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int KW     = 8
);
    localparam int RW = $clog2(N);

    logic                start;
    logic                acc_en;
    logic [KW-1:0]       k_len;
    logic                busy;
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] a_col;
    logic [N*DATA_W-1:0] b_row;
    logic                out_valid;
    logic                out_ready;
    logic [N*ACC_W-1:0]  out_row;
    logic [RW-1:0]       out_row_idx;
    logic                done;

    modport master (
        output start, acc_en, k_len, in_valid, a_col, b_row, out_ready,
        input  busy, in_ready, out_valid, out_row, out_row_idx, done
    );

    modport slave (
        input  start, acc_en, k_len, in_valid, a_col, b_row, out_ready,
        output busy, in_ready, out_valid, out_row, out_row_idx, done
    );
endinterface

// File: rtl/systolic_mma_engine.sv
// Output-stationary N x N systolic matrix multiplier: C = A*B or C += A*B,
// operands streamed one k-beat at a time, results drained one row per handshake.
module systolic_mma_engine #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int KW     = 8,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_mma_engine_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
    localparam bit SEXT = (SIGNED != 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

    state_t        state;
    logic [KW-1:0] k_len_q;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row_q;
    logic          busy_q, in_ready_q, out_valid_q, done_q;
    logic          beat, clr;

    // Operand buses carry {valid, data}; the valid bit gates every MAC.
    logic [DATA_W:0] a_in [N];
    logic [DATA_W:0] b_in [N];
    logic [DATA_W:0] a_pe [N][N];
    logic [DATA_W:0] b_pe [N][N];
    logic [N-1:0][N*ACC_W-1:0] acc_rows;

    assign beat = bus.in_valid && in_ready_q;
    assign clr  = (state == S_IDLE) && bus.start && !bus.acc_en;

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DATA_W:0] a_new, b_new;
        assign a_new = {beat, bus.a_col[i*DATA_W +: DATA_W]};
        assign b_new = {beat, bus.b_row[i*DATA_W +: DATA_W]};
        if (i == 0) begin : g_direct
            assign a_in[i] = a_new;
            assign b_in[i] = b_new;
        end else begin : g_delay
            logic [DATA_W:0] a_sk [i];
            logic [DATA_W:0] b_sk [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_sk[s] <= '0;
                        b_sk[s] <= '0;
                    end
                end else begin
                    a_sk[0] <= a_new;
                    b_sk[0] <= b_new;
                    for (int s = 1; s < i; s++) begin
                        a_sk[s] <= a_sk[s-1];
                        b_sk[s] <= b_sk[s-1];
                    end
                end
            end
            assign a_in[i] = a_sk[i-1];
            assign b_in[i] = b_sk[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_W:0] a_q, b_q, a_src, b_src;
            logic [ACC_W-1:0] acc_q, a_ext, b_ext;
            if (j == 0) begin : g_a_edge
                assign a_src = a_in[i];
            end else begin : g_a_hop
                assign a_src = a_pe[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_src = b_in[j];
            end else begin : g_b_hop
                assign b_src = b_pe[i-1][j];
            end
            assign a_ext = {{(ACC_W-DATA_W){SEXT & a_q[DATA_W-1]}}, a_q[DATA_W-1:0]};
            assign b_ext = {{(ACC_W-DATA_W){SEXT & b_q[DATA_W-1]}}, b_q[DATA_W-1:0]};
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q <= a_src;
                    b_q <= b_src;
                    if (clr)
                        acc_q <= '0;
                    else if (a_q[DATA_W] && b_q[DATA_W])
                        acc_q <= acc_q + a_ext * b_ext;
                end
            end
            assign a_pe[i][j] = a_q;
            assign b_pe[i][j] = b_q;
            assign acc_rows[i][j*ACC_W +: ACC_W] = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            k_len_q     <= '0;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    busy_q   <= 1'b1;
                    k_len_q  <= bus.k_len;
                    beat_cnt <= '0;
                    row_q    <= '0;
                    if (bus.k_len != '0) begin
                        state      <= S_LOAD;
                        in_ready_q <= 1'b1;
                    end else begin
                        state       <= S_DRAIN;
                        out_valid_q <= 1'b1;
                    end
                end
                S_LOAD: if (beat) begin
                    if (beat_cnt == k_len_q - KW'(1)) begin
                        state      <= S_FLUSH;
                        in_ready_q <= 1'b0;
                        flush_cnt  <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + KW'(1);
                    end
                end
                // Long enough for the last beat to reach PE(N-1,N-1).
                S_FLUSH: if (flush_cnt == FLUSH_LAST) begin
                    state       <= S_DRAIN;
                    out_valid_q <= 1'b1;
                end else begin
                    flush_cnt <= flush_cnt + FW'(1);
                end
                S_DRAIN: if (bus.out_ready) begin
                    if (row_q == ROW_LAST) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        row_q       <= '0;
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_row     = acc_rows[row_q];
    assign bus.out_row_idx = row_q;
    assign bus.done        = done_q;
    assign dbg_state       = state;
endmodule
